// File: rtl/t_pulse_debouncer.sv
// Pushbutton conditioner for the T flip-flop: synchronizes a raw button, debounces it and
// emits a single-clock toggle-enable pulse per accepted press, with optional hold-to-repeat.
module t_pulse_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       t_out,
    output logic       btn_level,
    output logic       busy,
    output logic [7:0] pulse_cnt,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             t_out_q, t_out_d;
    logic             btn_level_q, btn_level_d;
    logic             busy_q, busy_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;
    logic             btn_s;

    assign btn_s = sync1_q;

    always_comb begin
        sync0_d     = btn_in;
        sync1_d     = sync0_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rpt_d       = rpt_q;
        t_out_d     = 1'b0;
        btn_level_d = btn_level_q;
        pulse_cnt_d = pulse_cnt_q;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = PRESSED;
                    t_out_d     = 1'b1;
                    btn_level_d = 1'b1;
                    cnt_d       = '0;
                    rpt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = CNT_W'(1);
                end else if (REPEAT_CYCLES > 0) begin
                    if (rpt_q == RPT_LAST) begin
                        t_out_d = 1'b1;
                        rpt_d   = '0;
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
            end
            DEB_RELEASE: begin
                // A high sample here is bounce on release: back to held, no new pulse.
                if (btn_s) begin
                    state_d = PRESSED;
                    rpt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    btn_level_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (t_out_d) begin
            pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
        busy_d = (state_d == DEB_PRESS) || (state_d == DEB_RELEASE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync0_q     <= 1'b0;
            sync1_q     <= 1'b0;
            cnt_q       <= '0;
            rpt_q       <= '0;
            t_out_q     <= 1'b0;
            btn_level_q <= 1'b0;
            busy_q      <= 1'b0;
            pulse_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sync0_q     <= sync0_d;
            sync1_q     <= sync1_d;
            cnt_q       <= cnt_d;
            rpt_q       <= rpt_d;
            t_out_q     <= t_out_d;
            btn_level_q <= btn_level_d;
            busy_q      <= busy_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign t_out     = t_out_q;
    assign btn_level = btn_level_q;
    assign busy      = busy_q;
    assign pulse_cnt = pulse_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_t_pulse_debouncer.sv
// Bench for t_pulse_debouncer: two instances (no repeat, repeat of 8) share one button stimulus
// and are scored against a run-length model of the debounce rules; a T flip-flop rides on t_out.
module tb_t_pulse_debouncer;

    localparam int N  = 4;
    localparam int R1 = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b0;

    logic       t_out0, btn_level0, busy0;
    logic [7:0] pulse_cnt0;
    logic [1:0] state0;
    logic       t_out1, btn_level1, busy1;
    logic [7:0] pulse_cnt1;
    logic [1:0] state1;

    always #5 clk = ~clk;

    t_pulse_debouncer #(.DEBOUNCE_CYCLES(N), .REPEAT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .t_out(t_out0), .btn_level(btn_level0),
        .busy(busy0), .pulse_cnt(pulse_cnt0), .dbg_state(state0)
    );

    t_pulse_debouncer #(.DEBOUNCE_CYCLES(N), .REPEAT_CYCLES(R1)) dut1 (
        .clk(clk), .rst(rst), .btn_in(btn_in), .t_out(t_out1), .btn_level(btn_level1),
        .busy(busy1), .pulse_cnt(pulse_cnt1), .dbg_state(state1)
    );

    // Downstream T flip-flop driven straight from instance 0.
    logic tff;
    always @(posedge clk) begin
        if (rst) tff <= 1'b0;
        else if (t_out0) tff <= ~tff;
    end

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard: each entry is {expected pulse_cnt, cycle in which t_out must be high}.
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    // Reference model: btn_s is btn_in delayed by two edges; the debounced level flips once N
    // consecutive samples disagree with it; while held, every R further high samples repeat.
    int   cyc = 0;
    logic d0 = 1'b0, d1 = 1'b0;
    logic level[2];
    int   run[2];
    int   hold[2];
    int   cnt[2];
    logic fired_prev0 = 1'b0;
    logic tff_exp = 1'b0;

    task automatic cmp(input int i, input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL inst%0d %s cycle %0d: got %0d expected %0d", i, name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int i, input logic s, output logic fire);
        int rep;
        logic [31:0] e;
        rep  = (i == 0) ? 0 : R1;
        fire = 1'b0;
        if (!level[i]) begin
            if (s) begin
                run[i]++;
                if (run[i] == N) begin
                    level[i] = 1'b1;
                    run[i]   = 0;
                    hold[i]  = 0;
                    fire     = 1'b1;
                end
            end else begin
                run[i] = 0;
            end
        end else if (!s) begin
            run[i]++;
            if (run[i] == N) begin
                level[i] = 1'b0;
                run[i]   = 0;
            end
        end else if (run[i] > 0) begin
            run[i]  = 0;
            hold[i] = 0;
        end else if (rep > 0) begin
            hold[i]++;
            if (hold[i] == rep) begin
                hold[i] = 0;
                fire    = 1'b1;
            end
        end
        if (fire) begin
            cnt[i] = (cnt[i] + 1) % 256;
            e = {8'(cnt[i]), 24'(cyc)};
            if (i == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        logic s;
        logic f;
        cyc = cyc + 1;
        if (rst) begin
            d0 = 1'b0;
            d1 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                level[i] = 1'b0;
                run[i]   = 0;
                hold[i]  = 0;
                cnt[i]   = 0;
            end
            fired_prev0 = 1'b0;
            tff_exp     = 1'b0;
        end else begin
            if (fired_prev0) tff_exp = ~tff_exp;
            s  = d1;
            d1 = d0;
            d0 = btn_in;
            model_step(0, s, f);
            fired_prev0 = f;
            model_step(1, s, f);
        end
    end

    task automatic check_inst(input int i, input logic t, input logic lvl, input logic bsy,
                              input logic [7:0] pc, input logic [1:0] st);
        logic [31:0] e;
        logic        have;
        logic        exp_busy;
        have = 1'b0;
        e    = '0;
        if (i == 0 && exp_q0.size() > 0 && exp_q0[0][23:0] == cyc[23:0]) begin
            e = exp_q0.pop_front();
            have = 1'b1;
        end
        if (i == 1 && exp_q1.size() > 0 && exp_q1[0][23:0] == cyc[23:0]) begin
            e = exp_q1.pop_front();
            have = 1'b1;
        end
        exp_busy = (run[i] > 0);
        cmp(i, "t_out", int'(t), int'(have));
        if (have) cmp(i, "pulse_cnt_at_pulse", int'(pc), int'(e[31:24]));
        cmp(i, "pulse_cnt", int'(pc), cnt[i] % 256);
        cmp(i, "btn_level", int'(lvl), int'(level[i]));
        cmp(i, "busy", int'(bsy), int'(exp_busy));
        cmp(i, "state", int'(st), int'({level[i], exp_busy}));
    endtask

    // Monitor: samples on the falling edge, half a cycle after outputs settle.
    always @(negedge clk) begin
        check_inst(0, t_out0, btn_level0, busy0, pulse_cnt0, state0);
        check_inst(1, t_out1, btn_level1, busy1, pulse_cnt1, state1);
        cmp(0, "tff", int'(tff), int'(tff_exp));
    end

    task automatic drive(input logic b, input int n);
        for (int k = 0; k < n; k++) begin
            btn_in = b;
            @(negedge clk);
        end
    endtask

    initial begin
        logic pat[6];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        cmp(0, "reset_t_out", int'(t_out0), 0);
        cmp(0, "reset_btn_level", int'(btn_level0), 0);
        cmp(0, "reset_busy", int'(busy0), 0);
        cmp(0, "reset_pulse_cnt", int'(pulse_cnt0), 0);
        cmp(1, "reset_pulse_cnt", int'(pulse_cnt1), 0);
        rst = 1'b0;

        drive(1'b1, 12);
        drive(1'b0, 10);

        for (int k = 0; k < 6; k++) drive(pat[k], 1);
        drive(1'b0, 8);

        drive(1'b1, 10);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 10);

        drive(1'b1, 30);
        drive(1'b0, 10);

        // Reset lands while DEB_PRESS has cnt = 2; the held button must re-debounce from scratch.
        drive(1'b1, 4);
        rst = 1'b1;
        drive(1'b1, 1);
        cmp(0, "rst_mid_state", int'(state0), 0);
        cmp(0, "rst_mid_t_out", int'(t_out0), 0);
        rst = 1'b0;
        drive(1'b1, 10);
        drive(1'b0, 10);

        for (int k = 0; k < 150; k++) begin
            drive(1'b1, $urandom_range(1, 14));
            drive(1'b0, $urandom_range(1, 14));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                drive(btn_in, 1);
                rst = 1'b0;
            end
        end

        rst = 1'b1;
        drive(1'b0, 2);
        rst = 1'b0;
        for (int k = 0; k < 256; k++) begin
            drive(1'b1, $urandom_range(4, 12));
            drive(1'b0, $urandom_range(4, 10));
        end
        drive(1'b0, 5);
        cmp(0, "wrap_pulse_cnt", int'(pulse_cnt0), 0);
        cmp(0, "wrap_tff", int'(tff), 0);

        cmp(0, "leftover_expected", exp_q0.size(), 0);
        cmp(1, "leftover_expected", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
